mc_decoder_bus: RTL

Parametrised multicycle ARM control unit (decoder plus integrated main FSM) for the bus-attached core. Decodes Op/Funct/Rd into datapath controls. Adds a wider ALU op set: EOR, CMP, TST and MOV. Adds a request/ready memory-bus handshake with a wait-state timeout and a sticky fault state.

---
 rtl/mc_decoder_bus.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_decoder_bus.sv
// mc_decoder_bus: multicycle ARM control unit for the bus-attached core.
// Decodes Op/Funct/Rd into datapath controls and sequences the main FSM.
// Memory accesses use a request/ready handshake. A wait-state counter
// forces a sticky bus fault when the memory stalls for too long.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   Op, Funct  - instruction fields (Funct[5]=I, [4:1]=cmd, [0]=S/L)
//   Rd         - destination register
//   BusReady   - memory completes the current request this cycle
//   MemReq     - memory request active
//   MemW       - write strobe, held for the whole write request
//   IRWrite, NextPC, RegW, AdrSrc, ALUSrcA, PCS - 1-bit datapath controls
//   ResultSrc, ALUSrcB, ImmSrc, RegSrc, FlagW   - 2-bit datapath controls
//   ALUControl - ALU op select, zero-extended to ALUCTRL_W
//   Undef      - held high in FAULT when it was entered via Op=11
//   BusErr     - sticky, set when the bus timeout fires
module mc_decoder_bus #(
  parameter int unsigned ALUCTRL_W = 3,  // must be >= 3
  parameter int unsigned TIMEOUT   = 15  // 0 disables the timeout
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic                 BusReady,
  output logic                 MemReq,
  output logic                 MemW,
  output logic                 IRWrite,
  output logic                 NextPC,
  output logic                 RegW,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic                 PCS,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [1:0]           FlagW,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Undef,
  output logic                 BusErr
);

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBranch,
    StFault
  } state_e;

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned CntW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TimeoutLast = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutLast);

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            bus_err_q, bus_err_d;
  logic            undef_q, undef_d;

  // ---------------------------------------------------------------------------
  // ALU command decode (independent of state; gated by alu_op below)
  // ---------------------------------------------------------------------------
  logic [3:0] cmd;
  logic [2:0] alu_ctrl;
  logic       alu_valid;   // supported command
  logic       alu_wb;      // command writes a result register
  logic       alu_cmp_tst; // compare-style: flags only
  logic       alu_arith;   // ADD/SUB/CMP also update C/V

  assign cmd = Funct[4:1];

  always_comb begin
    alu_ctrl    = 3'b000;
    alu_valid   = 1'b0;
    alu_wb      = 1'b0;
    alu_cmp_tst = 1'b0;
    alu_arith   = 1'b0;
    case (cmd)
      4'b0100: begin // ADD
        alu_ctrl = 3'b000; alu_valid = 1'b1; alu_wb = 1'b1; alu_arith = 1'b1;
      end
      4'b0010: begin // SUB
        alu_ctrl = 3'b001; alu_valid = 1'b1; alu_wb = 1'b1; alu_arith = 1'b1;
      end
      4'b1010: begin // CMP
        alu_ctrl = 3'b001; alu_valid = 1'b1; alu_cmp_tst = 1'b1; alu_arith = 1'b1;
      end
      4'b0000: begin // AND
        alu_ctrl = 3'b010; alu_valid = 1'b1; alu_wb = 1'b1;
      end
      4'b1000: begin // TST
        alu_ctrl = 3'b010; alu_valid = 1'b1; alu_cmp_tst = 1'b1;
      end
      4'b1100: begin // ORR
        alu_ctrl = 3'b011; alu_valid = 1'b1; alu_wb = 1'b1;
      end
      4'b0001: begin // EOR
        alu_ctrl = 3'b100; alu_valid = 1'b1; alu_wb = 1'b1;
      end
      4'b1101: begin // MOV
        alu_ctrl = 3'b101; alu_valid = 1'b1; alu_wb = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Main FSM: next state and Moore/Mealy outputs
  // ---------------------------------------------------------------------------
  logic mem_req_st;
  logic alu_op;
  logic branch;
  logic timeout_hit;
  logic flag_s;

  assign timeout_hit = (TIMEOUT != 0) && mem_req_st && !BusReady && (wait_cnt_q == CntMax);

  always_comb begin
    state_d    = state_q;
    mem_req_st = 1'b0;
    MemW       = 1'b0;
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    RegW       = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcB    = 2'b00;
    alu_op     = 1'b0;
    branch     = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_req_st = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        IRWrite    = BusReady;
        NextPC     = BusReady;
        if (BusReady)         state_d = StDecode;
        else if (timeout_hit) state_d = StFault;
      end
      StDecode: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        unique case (Op)
          2'b00:   state_d = Funct[5] ? StExecuteI : StExecuteR;
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StFault;
        endcase
      end
      StMemAdr: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        mem_req_st = 1'b1;
        AdrSrc     = 1'b1;
        if (BusReady)         state_d = StMemWb;
        else if (timeout_hit) state_d = StFault;
      end
      StMemWrite: begin
        mem_req_st = 1'b1;
        AdrSrc     = 1'b1;
        MemW       = 1'b1;
        if (BusReady)         state_d = StFetch;
        else if (timeout_hit) state_d = StFault;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        state_d   = StFetch;
      end
      StExecuteR, StExecuteI: begin
        ALUSrcB = (state_q == StExecuteI) ? 2'b01 : 2'b00;
        alu_op  = 1'b1;
        state_d = alu_wb ? StAluWb : StFetch;
      end
      StAluWb: begin
        RegW    = 1'b1;
        state_d = StFetch;
      end
      StBranch: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
        state_d   = StFetch;
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StFault;
      end
    endcase
  end

  // Reset drops the request combinationally, even mid-transfer.
  assign MemReq = mem_req_st & reset;

  assign flag_s     = alu_op & alu_valid & (Funct[0] | alu_cmp_tst);
  assign FlagW      = {flag_s, flag_s & alu_arith};
  assign ALUControl = alu_op ? ALUCTRL_W'(alu_ctrl) : '0;
  assign PCS        = ((Rd == 4'hF) & RegW) | branch;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign Undef      = undef_q;
  assign BusErr     = bus_err_q;

  // ---------------------------------------------------------------------------
  // Wait counter and sticky flags
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (BusReady || (state_d != state_q)) begin
      wait_cnt_d = '0;
    end else if (mem_req_st && !(&wait_cnt_q)) begin
      // Saturate so a disabled timeout never wraps.
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  assign bus_err_d = bus_err_q | timeout_hit;
  assign undef_d   = undef_q | ((state_q == StDecode) && (Op == 2'b11));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StFetch;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
      undef_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
      undef_q    <= undef_d;
    end
  end

endmodule
